// File: rtl/uart_pkg.sv
// Shared UART constants and the tx-queue launcher state encoding.
// Used by uart_tx_queue and sync_fifo.
package uart_pkg;

  localparam int CLK_HZ         = 100_000_000;
  localparam int BAUD           = 115_200;
  localparam int CLKS_PER_BIT   = 868;
  localparam int FRAME_BITS     = 10;
  localparam int CLKS_PER_FRAME = CLKS_PER_BIT * FRAME_BITS;

  localparam int          OVF_W   = 16;
  localparam logic [15:0] OVF_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SEND = 2'd2
  } txq_state_e;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == OVF_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with AW+1 bit wrapping pointers.
// Storage is not reset; only the pointers are.
module sync_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          drop
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  // full comes from registered pointers, so a push
  // while full is dropped even if a pop lands too
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign drop    = push && full;

  assign rdata = mem[rd_ptr[AW-1:0]];

  // pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // storage write, no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter start/busy handshake.
// UART_TXQ_OVF_CNT_EN builds the saturating dropped-byte counter.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   ovf_count,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic          drained
);

  txq_state_e state;
  txq_state_e state_nxt;
  logic       pop;
  logic       start_nxt;
  logic [7:0] rdata;
  logic       drop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count),
    .drop  (drop)
  );

  // launcher next-state and pop decision
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          start_nxt = 1'b1;
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (tx_busy) state_nxt = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // launcher state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
      drained  <= 1'b1;
    end else begin
      tx_start <= start_nxt;
      if (pop) tx_data <= rdata;
      overflow <= drop;
      drained  <= empty && (state == S_IDLE) && !tx_busy;
    end
  end

`ifdef UART_TXQ_OVF_CNT_EN
  logic [15:0] ovf_q;

  // saturating dropped-byte counter
  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= '0;
    else if (drop) ovf_q <= sat_inc16(ovf_q);
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue with a behavioural transmitter
// and an expected-byte queue checked at every tx_start.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int SHORT = 20;
`ifdef UART_TXQ_OVF_CNT_EN
  localparam int T2_FRAME = 40;
`else
  localparam int T2_FRAME = CLKS_PER_FRAME;
`endif

  typedef struct {
    logic [7:0] d;
    logic [4:0] cnt;
    logic       f;
    logic       ov;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [15:0] ovf_count;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       drained;

  logic force_busy = 1'b0;
  logic mbusy = 1'b0;
  logic pend = 1'b0;
  logic start_d = 1'b0;
  int   bcnt = 0;
  int   frame_clks = SHORT;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   launches = 0;

  logic [7:0] exp_q[$];
  int         gap_q[$];
  int         tests = 0;
  int         fails = 0;

  assign tx_busy = force_busy | mbusy;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_count (ovf_count),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .drained   (drained)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // transmitter model: busy rises one cycle after it samples start
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    start_d <= tx_start;
    if (rst) begin
      mbusy <= 1'b0;
      pend  <= 1'b0;
    end else begin
      if (pend) begin
        mbusy <= 1'b1;
        bcnt  <= frame_clks - 1;
        pend  <= 1'b0;
      end else if (mbusy) begin
        if (bcnt == 0) begin
          mbusy    <= 1'b0;
          fall_cyc <= cyc;
        end else begin
          bcnt <= bcnt - 1;
        end
      end
      if (tx_start) begin
        launches <= launches + 1;
        pend     <= 1'b1;
        gap_q.push_back(cyc - 1 - fall_cyc);
        chk("start_pulse_len", start_d, 0);
        chk("start_link_idle", {pend, mbusy}, 0);
        if (exp_q.size() == 0)
          chk("unexpected_start", exp_q.size(), 1);
        else
          chk("tx_data_order", tx_data, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit ok);
    wr_en   = 1'b1;
    wr_data = d;
    if (ok) exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drained(input string nm, input int maxc);
    int n = 0;
    while (!(drained && !tx_busy && !pend && exp_q.size() == 0)
           && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < maxc, 1);
  endtask

  initial begin
    repeat (120000) @(posedge clk);
    fails++;
    $display("FAIL watchdog: got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    vec_t tbl[20];
    int   pulses;
    int   snap;
    int   n;

    for (int i = 0; i < 20; i++) begin
      tbl[i].d   = 8'(8'hA0 + i);
      tbl[i].cnt = 5'((i + 1 > DEPTH) ? DEPTH : i + 1);
      tbl[i].f   = (i + 1 >= DEPTH);
      tbl[i].ov  = (i >= DEPTH);
    end

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_drained", drained, 1);

    // single byte latency
    push(8'h55, 1);
    chk("t1_start_early", tx_start, 0);
    chk("t1_count", count, 1);
    chk("t1_drained_pre", drained, 1);
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'h55);
    chk("t1_drained_busy", drained, 0);
    @(negedge clk);
    chk("t1_start_once", tx_start, 0);
    wait_drained("t1_drain", 200);

    // three bytes, back-to-back launch spacing
    gap_q.delete();
    frame_clks = T2_FRAME;
    force_busy = 1'b1;
    push(8'h41, 1);
    push(8'h42, 1);
    push(8'h43, 1);
    chk("t2_peak", count, 3);
    force_busy = 1'b0;
    wait_drained("t2_drain", 3 * (T2_FRAME + 10) + 100);
    chk("t2_launches", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      chk("t2_gap_b", gap_q[1], 2);
      chk("t2_gap_c", gap_q[2], 2);
    end
    frame_clks = SHORT;

    // fill past full with the link held busy
    force_busy = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      wr_en   = 1'b1;
      wr_data = tbl[i].d;
      if (i < DEPTH) exp_q.push_back(tbl[i].d);
      @(negedge clk);
      chk($sformatf("t3_count_%0d", i), count, tbl[i].cnt);
      chk($sformatf("t3_full_%0d", i), full, tbl[i].f);
      chk($sformatf("t3_ovf_%0d", i), overflow, tbl[i].ov);
      pulses += int'(overflow);
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("t3_ovf_end", overflow, 0);
    chk("t3_pulses", pulses, 4);
    chk("t3_count_hold", count, DEPTH);
`ifdef UART_TXQ_OVF_CNT_EN
    chk("t3_ovf_count", ovf_count, 4);
`else
    chk("t3_ovf_count", ovf_count, 0);
`endif
    force_busy = 1'b0;
    wait_drained("t3_drain", DEPTH * (SHORT + 10) + 200);

    // push coinciding with pop, then wrap the pointers
    snap = launches;
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1);
    chk("t4_count5", count, 5);
    force_busy = 1'b0;
    push(8'h65, 1);
    chk("t4_simul_count", count, 5);
    chk("t4_simul_start", tx_start, 1);
    for (int k = 6; k < 40;) begin
      int b = $urandom_range(1, 4);
      for (int j = 0; j < b && k < 40; j++) begin
        push(8'(k * 7 + 3), 1);
        k++;
      end
      repeat (120) @(negedge clk);
    end
    wait_drained("t4_drain", 40 * (SHORT + 10) + 200);
    chk("t4_launches", launches - snap, 40);

    // reset while a frame is in flight
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i), 1);
    n = 0;
    while (!mbusy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_busy_seen", mbusy, 1);
    chk("t5_queued", count, 3);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_empty", empty, 1);
    chk("t5_count", count, 0);
    chk("t5_start", tx_start, 0);
    chk("t5_ovf_count", ovf_count, 0);
    rst = 1'b0;
    snap = launches;
    repeat (200) @(negedge clk);
    chk("t5_no_launch", launches - snap, 0);
    chk("t5_drained", drained, 1);

`ifdef UART_TXQ_OVF_CNT_EN
    // counter saturation
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1);
    wr_en = 1'b1;
    repeat (65540) @(negedge clk);
    wr_en = 1'b0;
    chk("t6_sat", ovf_count, 16'hFFFF);
    chk("t6_count", count, DEPTH);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    force_busy = 1'b0;
    chk("t6_clear", ovf_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte-buffering front end that sits directly upstream of the UART transmitter.
- Accepts bytes from the system side at full clock rate into a synchronous FIFO.
- A launcher FSM drains the FIFO one byte at a time through the transmitter's start/data/busy handshake.
- Decouples bursty producers (debug/log paths) from the 115200-baud serial link (868 clk/bit at 100 MHz).

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, 2..256
AW, $clog2(DEPTH), pointer address width (derived, not overridden)

Ports:
clk  input  1  100 MHz system clock
rst  input  1  synchronous, active-high reset
wr_en  input  1  push request
wr_data  input  8  byte to push
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: push dropped because full
ovf_count  output  16  dropped-byte counter (see Optional Feature)
tx_start  output  1  one-cycle start pulse to transmitter
tx_data  output  8  byte to transmitter
tx_busy  input  1  transmitter busy flag
drained  output  1  FIFO empty, FSM idle, tx_busy low

Behaviour:
- Reset: clk, rst as already decided (reset rst, synchronous, active-high; clock clk). Resets rd/wr pointers, count, FSM state (S_IDLE) and all outputs.
  - Output reset values: full=0, empty=1, count=0, overflow=0, ovf_count=0, tx_start=0, tx_data=8'h00, drained=1.
  - FIFO storage is not reset.
- Pointers: AW+1 bits wide, wrap naturally.
  - empty when the pointers are equal.
  - full when the MSBs differ and the low AW bits are equal.
  - count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Push: accepted iff wr_en && !full, using the registered full of that cycle.
  - wr_en && full: byte dropped, overflow=1 next cycle, no state change.
  - A push while full is dropped even if a pop occurs in the same cycle.
- Pop: performed only by the FSM. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- FSM:
  - S_IDLE: if !empty && !tx_busy, then tx_data<=mem[rd], rd_ptr++, tx_start<=1, ->S_ARM.
  - S_ARM: tx_start<=0. The transmitter raises busy one cycle after it samples start. Wait for tx_busy==1, then ->S_SEND.
  - S_SEND: wait for tx_busy==0, then ->S_IDLE.
- Transmitter busy-fall note: the transmitter drops busy one cycle after its stop bit ends, so no extra guard cycle is required.
- tx_start rules:
  - Never high for more than one cycle.
  - Never high outside the cycle after S_IDLE exits.
  - tx_data is stable from the tx_start cycle until the next tx_start.
- Latency: a byte pushed at edge N into an empty queue with the link idle gives tx_start=1 during the cycle after edge N+1.
- Back-to-back: the next tx_start occurs exactly 2 cycles after tx_busy falls, if the FIFO is non-empty.
- drained is registered: (empty && state==S_IDLE && !tx_busy).
- Reset mid-operation: the queue is flushed and the FSM returns to S_IDLE. The transmitter shares rst, so no partial-byte handshake survives reset.

Optional Feature:
- Macro: UART_TXQ_OVF_CNT_EN
- Defined: ovf_count increments by 1 on every dropped push and saturates at 16'hFFFF. It clears only on rst.
- Undefined: the counter logic is not built and ovf_count is tied to 16'h0000. The overflow pulse is still generated.

Decomposition:
- Shared package/header uart_pkg:
  - CLKS_PER_BIT=868 (shared with the transmitter).
  - Baud-derived constants.
  - txq FSM state encoding (S_IDLE=0, S_ARM=1, S_SEND=2).
- One natural sub-module: sync_fifo.
  - Parameterised by DEPTH and width 8.
  - Pointer logic, full/empty/count and storage.
- uart_tx_queue instantiates sync_fifo and adds the launcher FSM and overflow logic.

Test Plan:
1. Reset, then push 8'h55 once with the transmitter idle -> tx_start pulses 2 cycles after wr_en is sampled, with tx_data=8'h55. drained is 0 until busy falls, then returns to 1.
2. Push 8'h41,8'h42,8'h43 on consecutive cycles -> count peaks at 3. Serial line carries 'A','B','C' in order, each with a 10-bit frame of 8680 clks. Each tx_start is 2 cycles after the previous busy falls.
3. DEPTH=16: push 20 bytes back-to-back while tx_busy is held high by the bench -> full=1 after 16 pushes, 4 overflow pulses, count=16. With UART_TXQ_OVF_CNT_EN: ovf_count=4. Without the macro: ovf_count=0.
4. Simultaneous push and FSM pop at count=5 -> count stays 5. Byte order is preserved across pointer wrap after 40 total bytes.
5. Assert rst mid-frame, with 3 queued bytes and tx_busy high -> next cycle: empty=1, count=0, tx_start=0, FSM in S_IDLE. No further bytes are transmitted.
6. Saturation (macro defined): force 65540 dropped pushes -> ovf_count holds at 16'hFFFF.
